// File: rtl/dibu_cpu.sv
// DIBU 8-bit multicycle core: microcoded FSM, 8x8 register file, ALU with flags,
// 16-bit code memory (loaded while halted) and 8-bit data memory.
module dibu_cpu #(
   parameter int unsigned CODE_AW = 9,
   parameter int unsigned DATA_AW = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               code_w_en,
   input  logic [CODE_AW-1:0] code_addr_in,
   input  logic [15:0]        code_in,
   output logic [7:0]         debug
);

   localparam int unsigned DW         = 8;
   localparam int unsigned IW         = 16;
   localparam int unsigned NREG       = 8;
   localparam int unsigned CODE_DEPTH = 1 << CODE_AW;
   localparam int unsigned DATA_DEPTH = 1 << DATA_AW;

   localparam logic [4:0] OP_LDI = 5'b01000;
   localparam logic [4:0] OP_RDF = 5'b01001;
   localparam logic [4:0] OP_LDD = 5'b10000;
   localparam logic [4:0] OP_STD = 5'b10001;
   localparam logic [4:0] OP_LDX = 5'b10010;
   localparam logic [4:0] OP_STX = 5'b10011;

   // EXEC doubles as the first step of LD/ST (L1/S1), since ir is valid only after WAIT
   typedef enum logic [2:0] {
      S_FETCH, S_WAIT, S_EXEC, S_L2, S_L3, S_L4, S_S2
   } state_t;

   typedef enum logic [1:0] {
      DAR_IMM, DAR_DIR, DAR_REG
   } dar_src_t;

   state_t             state, state_n;
   logic [CODE_AW-1:0] pc, mar, code_addr;
   logic [IW-1:0]      ir;
   logic [DW-1:0]      dar, mdr, flags, dmem_dout;
   logic [DW-1:0]      regs [NREG];
   logic [IW-1:0]      code_mem [CODE_DEPTH];
   logic [DW-1:0]      data_mem [DATA_DEPTH];

   logic [4:0]    opcode;
   logic [2:0]    rd, ra, rb, aluop;
   logic [DW-1:0] imm, reg_a, reg_b, alu_out, alu_flags, bus, dar_in;
   logic          carry, ovf;

   logic          pc_inc, mar_ld, dar_ld, mdr_ld, mdr_from_mem;
   logic          reg_rw, flags_ld, dmem_w_en;
   logic [3:0]    bus_sel;
   dar_src_t      dar_src;

   assign opcode = ir[15:11];
   assign rd     = ir[10:8];
   assign ra     = ir[5:3];
   assign rb     = ir[2:0];
   assign imm    = ir[7:0];
   assign aluop  = ir[13:11];
   assign reg_a  = regs[ra];
   assign reg_b  = regs[rb];
   assign debug  = alu_out;

   // code memory: load port shares the address mux with fetch
   assign code_addr = code_w_en ? code_addr_in : mar;

   always_ff @(posedge clk) begin
      if (code_w_en) code_mem[code_addr] <= code_in;
   end

   always_ff @(posedge clk) begin
      if (rst) ir <= '0;
      else     ir <= code_mem[code_addr];
   end

   // data memory, 8-bit address zero-extended
   always_ff @(posedge clk) begin
      if (dmem_w_en) data_mem[DATA_AW'(dar)] <= mdr;
      dmem_dout <= data_mem[DATA_AW'(dar)];
   end

   // ALU
   always_comb begin
      alu_out = '0;
      carry   = 1'b0;
      ovf     = 1'b0;
      unique case (aluop)
         3'd0: begin
            {carry, alu_out} = {1'b0, reg_a} + {1'b0, reg_b};
            ovf = (reg_a[7] == reg_b[7]) && (alu_out[7] != reg_a[7]);
         end
         3'd1: begin
            {carry, alu_out} = {1'b0, reg_a} - {1'b0, reg_b};
            ovf = (reg_a[7] != reg_b[7]) && (alu_out[7] != reg_a[7]);
         end
         3'd2: alu_out = reg_a & reg_b;
         3'd3: alu_out = reg_a | reg_b;
         3'd4: alu_out = reg_a ^ reg_b;
         3'd5: alu_out = ~reg_a;
         3'd6: begin
            alu_out = {reg_a[6:0], 1'b0};
            carry   = reg_a[7];
         end
         3'd7: begin
            alu_out = {1'b0, reg_a[7:1]};
            carry   = reg_a[0];
         end
         default: alu_out = '0;
      endcase
      alu_flags = {4'b0000, ovf, alu_out[7], carry, (alu_out == 8'h00)};
   end

   assign bus = ({DW{bus_sel[0]}} & alu_out) |
                ({DW{bus_sel[1]}} & flags)   |
                ({DW{bus_sel[2]}} & imm)     |
                ({DW{bus_sel[3]}} & mdr);

   always_comb begin
      unique case (dar_src)
         DAR_DIR: dar_in = ir[10:3];
         DAR_REG: dar_in = reg_a;
         default: dar_in = imm;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_n;
   end

   // microsequencer
   always_comb begin
      state_n      = state;
      pc_inc       = 1'b0;
      mar_ld       = 1'b0;
      dar_ld       = 1'b0;
      dar_src      = DAR_IMM;
      mdr_ld       = 1'b0;
      mdr_from_mem = 1'b0;
      reg_rw       = 1'b0;
      bus_sel      = 4'b0000;
      flags_ld     = 1'b0;
      dmem_w_en    = 1'b0;
      unique case (state)
         S_FETCH: begin
            mar_ld  = 1'b1;
            pc_inc  = 1'b1;
            state_n = S_WAIT;
         end
         S_WAIT: state_n = S_EXEC;
         S_EXEC: begin
            state_n = S_FETCH;
            if (opcode[4:3] == 2'b00) begin
               reg_rw   = 1'b1;
               bus_sel  = 4'b0001;
               flags_ld = 1'b1;
            end else begin
               unique case (opcode)
                  OP_LDI: begin
                     reg_rw  = 1'b1;
                     bus_sel = 4'b0100;
                  end
                  OP_RDF: begin
                     reg_rw  = 1'b1;
                     bus_sel = 4'b0010;
                  end
                  OP_LDD, OP_LDX: begin
                     dar_ld  = 1'b1;
                     dar_src = (opcode == OP_LDX) ? DAR_REG : DAR_IMM;
                     state_n = S_L2;
                  end
                  OP_STD, OP_STX: begin
                     dar_ld  = 1'b1;
                     dar_src = (opcode == OP_STX) ? DAR_REG : DAR_DIR;
                     mdr_ld  = 1'b1;
                     state_n = S_S2;
                  end
                  default: state_n = S_FETCH;
               endcase
            end
         end
         S_L2: state_n = S_L3;
         S_L3: begin
            mdr_ld       = 1'b1;
            mdr_from_mem = 1'b1;
            state_n      = S_L4;
         end
         S_L4: begin
            reg_rw  = 1'b1;
            bus_sel = 4'b1000;
            state_n = S_FETCH;
         end
         S_S2: begin
            dmem_w_en = 1'b1;
            state_n   = S_FETCH;
         end
         default: state_n = S_FETCH;
      endcase
      // halted: freeze the sequencer and suppress every write
      if (!run) begin
         state_n   = state;
         pc_inc    = 1'b0;
         mar_ld    = 1'b0;
         dar_ld    = 1'b0;
         mdr_ld    = 1'b0;
         reg_rw    = 1'b0;
         flags_ld  = 1'b0;
         dmem_w_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc    <= '0;
         mar   <= '0;
         dar   <= '0;
         mdr   <= '0;
         flags <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (pc_inc)   pc    <= pc + CODE_AW'(1);
         if (mar_ld)   mar   <= pc;
         if (dar_ld)   dar   <= dar_in;
         if (mdr_ld)   mdr   <= mdr_from_mem ? dmem_dout : reg_b;
         if (flags_ld) flags <= alu_flags;
         if (reg_rw)   regs[rd] <= bus;
      end
   end

endmodule

// File: tb/tb_dibu_cpu.sv
// Scoreboard bench for dibu_cpu: programs are executed by an instruction-level model that
// predicts debug for each instruction's first execute cycle; a monitor compares on negedges.
module tb_dibu_cpu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        code_w_en = 1'b0;
   logic [8:0]  code_addr_in = '0;
   logic [15:0] code_in = '0;
   logic [7:0]  debug;

   dibu_cpu dut (
      .clk(clk), .rst(rst), .run(run), .code_w_en(code_w_en),
      .code_addr_in(code_addr_in), .code_in(code_in), .debug(debug)
   );

   typedef struct {
      int         cyc;
      logic [7:0] val;
      int         idx;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] prog[$];
   logic [7:0]  dmem_m [256];
   int          known_list[$];
   int          act_cyc = 0;
   int          checks = 0;
   int          errors = 0;

   initial forever #5 clk = ~clk;

   // cycles executed with run=1 since the last reset
   initial forever begin
      @(posedge clk);
      if (rst)      act_cyc = 0;
      else if (run) act_cyc++;
   end

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, got, want);
      end
   endtask

   // monitor: debug sampled mid-cycle in each instruction's first execute cycle
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst && run && exp_q.size() > 0) begin
         if (exp_q[0].cyc == act_cyc) begin
            e = exp_q.pop_front();
            check($sformatf("debug instr %0d cyc %0d", e.idx, e.cyc), debug, e.val);
         end else if (exp_q[0].cyc < act_cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed instr %0d: expected at cyc %0d, now %0d", e.idx, e.cyc, act_cyc);
         end
      end
   end

   function automatic logic [15:0] enc_alu(input logic [2:0] op, input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
      return {2'b00, op, d, 2'b00, a, b};
   endfunction
   function automatic logic [15:0] enc_ldi(input logic [2:0] d, input logic [7:0] v);
      return {5'b01000, d, v};
   endfunction
   function automatic logic [15:0] enc_rdf(input logic [2:0] d);
      return {5'b01001, d, 8'h00};
   endfunction
   function automatic logic [15:0] enc_ldd(input logic [2:0] d, input logic [7:0] ad);
      return {5'b10000, d, ad};
   endfunction
   function automatic logic [15:0] enc_ldx(input logic [2:0] d, input logic [2:0] a);
      return {5'b10010, d, 2'b00, a, 3'b000};
   endfunction
   function automatic logic [15:0] enc_std(input logic [7:0] ad, input logic [2:0] b);
      return {5'b10001, ad, b};
   endfunction
   function automatic logic [15:0] enc_stx(input logic [2:0] a, input logic [2:0] b);
      return {5'b10011, 3'b000, 2'b00, a, b};
   endfunction
   // undefined opcode whose OR alu field exposes R[r] on debug without writing anything
   function automatic logic [15:0] enc_probe(input logic [2:0] r);
      return {5'b11011, 3'b000, 2'b00, r, r};
   endfunction

   function automatic void alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                     output logic [7:0] o, output logic [7:0] f);
      int  s;
      logic c;
      logic v;
      c = 1'b0;
      v = 1'b0;
      o = 8'h00;
      case (op)
         3'd0: begin
            s = int'(a) + int'(b);
            o = 8'(s);
            c = (s > 255);
            s = int'($signed(a)) + int'($signed(b));
            v = (s > 127) || (s < -128);
         end
         3'd1: begin
            o = 8'(int'(a) - int'(b));
            c = (a < b);
            s = int'($signed(a)) - int'($signed(b));
            v = (s > 127) || (s < -128);
         end
         3'd2: o = a & b;
         3'd3: o = a | b;
         3'd4: o = a ^ b;
         3'd5: o = 8'(255 - int'(a));
         3'd6: begin
            o = 8'(int'(a) * 2);
            c = (a >= 8'd128);
         end
         default: begin
            o = 8'(int'(a) / 2);
            c = (a % 2) == 1;
         end
      endcase
      f = {4'b0000, v, o[7], c, (o == 8'h00)};
   endfunction

   // instruction-level execution of prog from reset state; pushes expected debug values
   task automatic model_run();
      logic [7:0]  r [8];
      logic [7:0]  fl, res, af;
      logic [15:0] w;
      exp_t        e;
      int          cyc;
      for (int j = 0; j < 8; j++) r[j] = 8'h00;
      fl  = 8'h00;
      cyc = 0;
      for (int i = 0; i < prog.size(); i++) begin
         w = prog[i];
         alu_model(w[13:11], r[w[5:3]], r[w[2:0]], res, af);
         e.cyc = cyc + 2;
         e.val = res;
         e.idx = i;
         exp_q.push_back(e);
         if (w[15:14] == 2'b00) begin
            r[w[10:8]] = res;
            fl  = af;
            cyc += 3;
         end else begin
            case (w[15:11])
               5'b01000: begin r[w[10:8]] = w[7:0];            cyc += 3; end
               5'b01001: begin r[w[10:8]] = fl;                cyc += 3; end
               5'b10000: begin r[w[10:8]] = dmem_m[w[7:0]];    cyc += 6; end
               5'b10010: begin r[w[10:8]] = dmem_m[r[w[5:3]]]; cyc += 6; end
               5'b10001: begin dmem_m[w[10:3]] = r[w[2:0]];    cyc += 4; end
               5'b10011: begin dmem_m[r[w[5:3]]] = r[w[2:0]];  cyc += 4; end
               default:  cyc += 3;
            endcase
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load_prog();
      run = 1'b0;
      for (int i = 0; i < prog.size() + 4; i++) begin
         code_w_en    = 1'b1;
         code_addr_in = 9'(i);
         code_in      = (i < prog.size()) ? prog[i] : 16'hF800;
         tick();
      end
      code_w_en = 1'b0;
      tick();
   endtask

   // mode 0: plain, 1: random run drops, 2: 2-cycle drop at `at`, 3: reset at `at`
   task automatic run_prog(input int mode, input int at);
      int budget;
      bit did_rst;
      budget  = 0;
      did_rst = 1'b0;
      run = 1'b1;
      while (exp_q.size() > 0 && budget < 5000) begin
         tick();
         budget++;
         if (mode == 1 && $urandom_range(0, 7) == 0) begin
            run = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            run = 1'b1;
         end else if (mode == 2 && act_cyc == at) begin
            run = 1'b0;
            tick();
            tick();
            run = 1'b1;
         end else if (mode == 3 && !did_rst && act_cyc == at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            did_rst = 1'b1;
            exp_q.delete();
            model_run();
         end
      end
      run = 1'b0;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d expected outputs never seen", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic load_and_run(input int mode, input int at);
      load_prog();
      do_reset();
      check("reset debug", debug, 8'h00);
      model_run();
      run_prog(mode, at);
   endtask

   task automatic gen_random(input int n);
      logic [2:0] rd, ra, rb;
      logic [7:0] ad;
      int         k, v;
      prog.delete();
      for (int i = 0; i < n; i++) begin
         rd = 3'($urandom_range(0, 7));
         ra = 3'($urandom_range(0, 7));
         rb = 3'($urandom_range(0, 7));
         ad = 8'($urandom_range(0, 255));
         k  = $urandom_range(0, 9);
         if ((k == 5 || k == 6) && known_list.size() == 0) k = 7;
         case (k)
            0, 1, 2: prog.push_back(enc_alu(3'($urandom_range(0, 7)), rd, ra, rb));
            3: prog.push_back(enc_ldi(rd, 8'($urandom_range(0, 255))));
            4: prog.push_back(enc_rdf(rd));
            5: prog.push_back(enc_ldd(rd, 8'(known_list[$urandom_range(0, known_list.size() - 1)])));
            6: begin
               prog.push_back(enc_ldi(ra, 8'(known_list[$urandom_range(0, known_list.size() - 1)])));
               prog.push_back(enc_ldx(rd, ra));
            end
            7: begin
               prog.push_back(enc_std(ad, rb));
               known_list.push_back(int'(ad));
            end
            8: begin
               prog.push_back(enc_ldi(ra, ad));
               prog.push_back(enc_stx(ra, rb));
               known_list.push_back(int'(ad));
            end
            default: begin
               v = $urandom_range(0, 17);
               prog.push_back({5'((v < 6) ? 10 + v : 14 + v), 11'($urandom_range(0, 2047))});
            end
         endcase
         prog.push_back(enc_probe(rd));
      end
   endtask

   initial begin
      do_reset();
      check("reset debug", debug, 8'h00);

      // arithmetic and flag corner cases
      prog.delete();
      prog.push_back(enc_ldi(3'd1, 8'h05));
      prog.push_back(enc_ldi(3'd2, 8'h03));
      prog.push_back(enc_alu(3'd0, 3'd3, 3'd1, 3'd2));
      prog.push_back(enc_probe(3'd3));
      prog.push_back(enc_rdf(3'd7));
      prog.push_back(enc_probe(3'd7));
      prog.push_back(enc_alu(3'd1, 3'd4, 3'd1, 3'd1));
      prog.push_back(enc_rdf(3'd7));
      prog.push_back(enc_probe(3'd7));
      prog.push_back(enc_alu(3'd1, 3'd4, 3'd2, 3'd1));
      prog.push_back(enc_rdf(3'd7));
      prog.push_back(enc_probe(3'd7));
      prog.push_back(enc_ldi(3'd1, 8'h7F));
      prog.push_back(enc_ldi(3'd2, 8'h01));
      prog.push_back(enc_alu(3'd0, 3'd5, 3'd1, 3'd2));
      prog.push_back(enc_rdf(3'd7));
      prog.push_back(enc_probe(3'd7));
      prog.push_back(enc_ldi(3'd1, 8'hFF));
      prog.push_back(enc_alu(3'd0, 3'd5, 3'd1, 3'd2));
      prog.push_back(16'hFFFF);
      prog.push_back(enc_rdf(3'd6));
      prog.push_back(enc_probe(3'd6));
      prog.push_back(enc_probe(3'd5));
      load_and_run(0, 0);

      // direct and indirect store/load, with a 2-cycle halt during the direct load
      prog.delete();
      prog.push_back(enc_ldi(3'd1, 8'h5A));
      prog.push_back(enc_std(8'h20, 3'd1));
      prog.push_back(enc_ldd(3'd6, 8'h20));
      prog.push_back(enc_probe(3'd6));
      prog.push_back(enc_ldi(3'd2, 8'h21));
      prog.push_back(enc_ldi(3'd3, 8'hA5));
      prog.push_back(enc_stx(3'd2, 3'd3));
      prog.push_back(enc_ldx(3'd5, 3'd2));
      prog.push_back(enc_probe(3'd5));
      known_list.push_back(32);
      known_list.push_back(33);
      load_and_run(2, 10);

      // reset while running restarts at address 0 with cleared registers
      prog.delete();
      prog.push_back(enc_probe(3'd1));
      prog.push_back(enc_probe(3'd2));
      prog.push_back(enc_ldi(3'd1, 8'h11));
      prog.push_back(enc_ldi(3'd2, 8'h22));
      prog.push_back(enc_alu(3'd0, 3'd3, 3'd1, 3'd2));
      prog.push_back(enc_probe(3'd3));
      prog.push_back(enc_rdf(3'd4));
      prog.push_back(enc_probe(3'd4));
      load_and_run(3, 14);

      for (int p = 0; p < 6; p++) begin
         gen_random(20);
         load_and_run(p % 2, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
